hole_fill: RTL and testbench

Scanline hole-filling stage of the disparity post-processing chain. It sits directly upstream of the median filter and produces its `disp_hole` / `valid_final_hole` stream. Each pixel carrying the invalid-disparity code is replaced by the last valid disparity seen to its left on the same row, for a bounded run length. All other pixels pass through unchanged.

---
 rtl/hole_fill.sv | 181 ++++++++++++++++++
 tb/tb_hole_fill.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hole_fill.sv
// hole_fill: scanline hole filler in front of the median filter.
// Each invalid-disparity pixel is replaced by the last valid disparity to its
// left on the same row, for at most MAX_RUN consecutive holes.
// Two-stage pipeline: S1 tags the pixel (col 0, row end, hole), S2 applies the fill rule.
// Optional: define HOLE_FILL_STAT_EN to enable the per-frame hole counter on hole_cnt.
module hole_fill #(
    parameter int unsigned   DW      = 9,
    parameter int unsigned   WW      = 11,
    parameter logic [DW-1:0] INVALID = {DW{1'b1}},
    parameter int unsigned   MAX_RUN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clken,
    input  logic          enable,
    input  logic [WW-1:0] width,
    input  logic          valid_in,
    input  logic [DW-1:0] disp_in,
    output logic [DW-1:0] disp_hole,
    output logic          valid_final_hole,
    output logic          row_end,
    output logic [19:0]   hole_cnt
);

    localparam logic [7:0]    MaxRun8 = 8'(MAX_RUN);
    localparam logic [WW-1:0] OneW    = WW'(1);

    // Column tracking
    logic          accept;
    logic [WW-1:0] col_q, col_d;
    logic [WW-1:0] row_w_q, row_w_d;
    logic [WW-1:0] col_cur;
    logic [WW-1:0] row_w;
    logic [WW-1:0] last_col;
    logic          at_col0;
    logic          is_row_end;

    // S1 registers
    logic          s1_valid;
    logic [DW-1:0] s1_disp;
    logic          s1_col0;
    logic          s1_row_end;
    logic          s1_hole;

    // Fill state (owned by S2)
    logic [DW-1:0] last_q, last_d;
    logic          have_q, have_d;
    logic [7:0]    run_q, run_d;
    logic          have_eff;
    logic [7:0]    run_eff;
    logic          fill_ok;
    logic [DW-1:0] out_d;

    assign accept  = clken & valid_in;
    // enable restarts the frame, so a pixel arriving with it is column 0
    assign col_cur = enable ? '0 : col_q;
    assign at_col0 = (col_cur == '0);
    // Row length is taken from the port at each row start and held for the row
    assign row_w    = at_col0 ? width : row_w_q;
    // width 0 behaves like width 1: every pixel is both col 0 and row end
    assign last_col   = (row_w == '0) ? '0 : row_w - OneW;
    assign is_row_end = (col_cur == last_col);

    // Next column count and latched row length
    always_comb begin
        col_d   = col_q;
        row_w_d = row_w_q;
        if (enable) begin
            col_d = '0;
        end
        if (accept) begin
            row_w_d = row_w;
            col_d   = is_row_end ? '0 : col_cur + OneW;
        end
    end

    // Column counter state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= '0;
            row_w_q <= '0;
        end else begin
            col_q   <= col_d;
            row_w_q <= row_w_d;
        end
    end

    // S1: capture the accepted pixel and its tags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_disp    <= '0;
            s1_col0    <= 1'b0;
            s1_row_end <= 1'b0;
            s1_hole    <= 1'b0;
        end else if (enable || clken) begin
            s1_valid <= accept;
            if (accept) begin
                s1_disp    <= disp_in;
                s1_col0    <= at_col0;
                s1_row_end <= is_row_end;
                s1_hole    <= (disp_in == INVALID);
            end
        end
    end

    // Row start hides any fill state left over from the previous row
    assign have_eff = s1_col0 ? 1'b0 : have_q;
    assign run_eff  = s1_col0 ? 8'd0 : run_q;
    assign fill_ok  = have_eff && (run_eff < MaxRun8);

    // S2 fill rule: next output and next fill state
    always_comb begin
        out_d  = disp_hole;
        last_d = last_q;
        have_d = have_q;
        run_d  = run_q;
        if (s1_valid) begin
            have_d = have_eff;
            run_d  = run_eff;
            if (!s1_hole) begin
                out_d  = s1_disp;
                last_d = s1_disp;
                have_d = 1'b1;
                run_d  = 8'd0;
            end else if (fill_ok) begin
                out_d = last_q;
                run_d = run_eff + 8'd1;
            end else begin
                // Unfillable hole; run stays where it is (saturated or zero)
                out_d = '0;
            end
        end
    end

    // S2 registers: outputs and fill state; enable flushes in-flight pixels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_final_hole <= 1'b0;
            row_end          <= 1'b0;
            disp_hole        <= '0;
            last_q           <= '0;
            have_q           <= 1'b0;
            run_q            <= 8'd0;
        end else if (enable) begin
            valid_final_hole <= 1'b0;
            row_end          <= 1'b0;
            disp_hole        <= '0;
            last_q           <= '0;
            have_q           <= 1'b0;
            run_q            <= 8'd0;
        end else if (clken) begin
            valid_final_hole <= s1_valid;
            row_end          <= s1_valid & s1_row_end;
            disp_hole        <= out_d;
            last_q           <= last_d;
            have_q           <= have_d;
            run_q            <= run_d;
        end
    end

`ifdef HOLE_FILL_STAT_EN
    logic [19:0] hole_cnt_q;

    // Saturating per-frame hole counter, counted as holes pass through S2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hole_cnt_q <= '0;
        end else if (enable) begin
            hole_cnt_q <= '0;
        end else if (clken && s1_valid && s1_hole && (hole_cnt_q != '1)) begin
            hole_cnt_q <= hole_cnt_q + 20'd1;
        end
    end

    assign hole_cnt = hole_cnt_q;
`else
    assign hole_cnt = '0;
`endif

endmodule

// File: tb/tb_hole_fill.sv
// Directed bench for hole_fill (MAX_RUN = 2). Outputs are captured on the
// falling edge whenever a valid result is consumed (clken high).
module tb_hole_fill;

    logic        clk;
    logic        rst;
    logic        clken;
    logic        enable;
    logic [10:0] width;
    logic        valid_in;
    logic [8:0]  disp_in;
    logic [8:0]  disp_hole;
    logic        valid_final_hole;
    logic        row_end;
    logic [19:0] hole_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] got_d[$];
    logic       got_re[$];
    logic [8:0] exp_d[$];
    logic       exp_re[$];

    hole_fill #(
        .DW(9),
        .WW(11),
        .INVALID(9'd511),
        .MAX_RUN(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clken(clken),
        .enable(enable),
        .width(width),
        .valid_in(valid_in),
        .disp_in(disp_in),
        .disp_hole(disp_hole),
        .valid_final_hole(valid_final_hole),
        .row_end(row_end),
        .hole_cnt(hole_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Capture each consumed output; row_end must never appear without valid
    always @(negedge clk) begin
        if (rst) begin
            if (row_end && !valid_final_hole) check("row_end_without_valid", 1, 0);
            if (valid_final_hole && clken) begin
                got_d.push_back(disp_hole);
                got_re.push_back(row_end);
            end
        end
    end

    task automatic step(input logic v, input logic [8:0] d, input logic ce, input logic en);
        valid_in = v;
        disp_in  = d;
        clken    = ce;
        enable   = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 9'd0, 1'b1, 1'b0);
    endtask

    task automatic check_stream(input string tag);
        check($sformatf("%s_count", tag), got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < got_d.size()) begin
                check($sformatf("%s_disp[%0d]", tag, i), got_d[i], exp_d[i]);
                check($sformatf("%s_row_end[%0d]", tag, i), got_re[i], exp_re[i]);
            end
        end
        got_d.delete();
        got_re.delete();
        exp_d.delete();
        exp_re.delete();
    endtask

    logic [19:0] cnt_exp;

    initial begin
`ifdef HOLE_FILL_STAT_EN
        cnt_exp = 20'd1;
`else
        cnt_exp = 20'd0;
`endif
        rst      = 1'b0;
        clken    = 1'b0;
        enable   = 1'b0;
        width    = 11'd4;
        valid_in = 1'b0;
        disp_in  = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_disp", disp_hole, 0);
        check("reset_valid", valid_final_hole, 0);
        check("reset_row_end", row_end, 0);
        check("reset_hole_cnt", hole_cnt, 0);
        rst = 1'b1;

        // Basic fill plus latency
        width = 11'd4;
        step(1'b1, 9'd10, 1'b1, 1'b0);
        check("lat_not_yet", valid_final_hole, 0);
        step(1'b1, 9'd511, 1'b1, 1'b0);
        check("lat_valid", valid_final_hole, 1);
        check("lat_disp", disp_hole, 10);
        step(1'b1, 9'd511, 1'b1, 1'b0);
        step(1'b1, 9'd12, 1'b1, 1'b0);
        idle(4);
        exp_d = '{9'd10, 9'd10, 9'd10, 9'd12};
        exp_re = '{1'b0, 1'b0, 1'b0, 1'b1};
        check_stream("basic");

        // Row boundary: no fill across rows
        width = 11'd3;
        step(1'b1, 9'd7, 1'b1, 1'b0);
        step(1'b1, 9'd8, 1'b1, 1'b0);
        step(1'b1, 9'd9, 1'b1, 1'b0);
        step(1'b1, 9'd511, 1'b1, 1'b0);
        step(1'b1, 9'd5, 1'b1, 1'b0);
        step(1'b1, 9'd6, 1'b1, 1'b0);
        idle(4);
        exp_d = '{9'd7, 9'd8, 9'd9, 9'd0, 9'd5, 9'd6};
        exp_re = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        check_stream("rowbound");

        // Run limit of 2
        width = 11'd8;
        step(1'b1, 9'd20, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 9'd511, 1'b1, 1'b0);
        step(1'b1, 9'd30, 1'b1, 1'b0);
        step(1'b1, 9'd511, 1'b1, 1'b0);
        step(1'b1, 9'd511, 1'b1, 1'b0);
        idle(4);
        exp_d = '{9'd20, 9'd20, 9'd20, 9'd0, 9'd0, 9'd30, 9'd30, 9'd30};
        exp_re = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_stream("runlim");

        // clken stall: outputs hold, no pixel taken while low
        width = 11'd4;
        step(1'b1, 9'd1, 1'b1, 1'b0);
        step(1'b1, 9'd2, 1'b1, 1'b0);
        step(1'b1, 9'd99, 1'b0, 1'b0);
        check("stall1_valid", valid_final_hole, 1);
        check("stall1_disp", disp_hole, 1);
        step(1'b1, 9'd99, 1'b0, 1'b0);
        check("stall2_valid", valid_final_hole, 1);
        check("stall2_disp", disp_hole, 1);
        step(1'b1, 9'd511, 1'b1, 1'b0);
        step(1'b1, 9'd3, 1'b1, 1'b0);
        idle(4);
        exp_d = '{9'd1, 9'd2, 9'd2, 9'd3};
        exp_re = '{1'b0, 1'b0, 1'b0, 1'b1};
        check_stream("clken");

        // enable mid-row with a hole: flushes S1, hole becomes col 0
        width = 11'd4;
        step(1'b1, 9'd40, 1'b1, 1'b0);
        step(1'b1, 9'd41, 1'b1, 1'b0);
        step(1'b1, 9'd511, 1'b1, 1'b1);
        step(1'b1, 9'd42, 1'b1, 1'b0);
        idle(4);
        exp_d = '{9'd40, 9'd0, 9'd42};
        exp_re = '{1'b0, 1'b0, 1'b0};
        check_stream("enable");
        check("enable_hole_cnt", hole_cnt, cnt_exp);

        // Asynchronous reset mid-row
        step(1'b1, 9'd50, 1'b1, 1'b0);
        step(1'b1, 9'd51, 1'b1, 1'b0);
        check("prerst_valid", valid_final_hole, 1);
        rst = 1'b0;
        #1;
        check("rst_disp", disp_hole, 0);
        check("rst_valid", valid_final_hole, 0);
        check("rst_row_end", row_end, 0);
        check("rst_hole_cnt", hole_cnt, 0);
        step(1'b0, 9'd0, 1'b0, 1'b0);
        got_d.delete();
        got_re.delete();
        rst = 1'b1;
        step(1'b1, 9'd511, 1'b1, 1'b0);
        step(1'b1, 9'd60, 1'b1, 1'b0);
        step(1'b1, 9'd61, 1'b1, 1'b0);
        step(1'b1, 9'd62, 1'b1, 1'b0);
        idle(4);
        exp_d = '{9'd0, 9'd60, 9'd61, 9'd62};
        exp_re = '{1'b0, 1'b0, 1'b0, 1'b1};
        check_stream("postrst");
        check("postrst_hole_cnt", hole_cnt, cnt_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
